mario_ctrl: RTL and testbench

MARIO_CTRL -- requirements
Module: mario_ctrl

---
 rtl/mario_ctrl.sv | 176 +++++++++++++++++
 tb/tb_mario_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mario_ctrl.sv
// Player-character controller: walking, jumping and sprite selection.
// All state advances only on the frame tick strobe.
module mario_ctrl #(
    parameter int X_RESET   = 64,
    parameter int X_MIN     = 0,
    parameter int X_MAX     = 640,
    parameter int GROUND_Y  = 704,
    parameter int WALK_STEP = 4,
    parameter int JUMP_V    = 20,
    parameter int MAX_FALL  = 16,
    parameter int ANIM_DIV  = 4,
    parameter int ID_STAND  = 10,
    parameter int ID_WALK0  = 11,
    parameter int ID_JUMP   = 14,
    parameter int LEFT_OFS  = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        tick,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        btn_jump,
    output logic [10:0] mario_x,
    output logic [9:0]  mario_y,
    output logic [5:0]  mario_id,
    output logic        right,
    output logic        airborne
);

    typedef enum logic [1:0] {IDLE, WALK, JUMP_UP, FALL} state_t;

    localparam logic [10:0] X_RESET_W  = 11'(X_RESET);
    localparam logic [10:0] X_MIN_W    = 11'(X_MIN);
    localparam logic [10:0] X_MAX_W    = 11'(X_MAX);
    localparam logic [11:0] X_MIN_12   = 12'(X_MIN);
    localparam logic [11:0] X_MAX_12   = 12'(X_MAX);
    localparam logic [11:0] STEP_12    = 12'(WALK_STEP);
    localparam logic [9:0]  GROUND_W   = 10'(GROUND_Y);
    localparam logic [10:0] GROUND_11  = 11'(GROUND_Y);
    localparam logic [5:0]  JUMP_V_W   = 6'(JUMP_V);
    localparam logic [5:0]  MAX_FALL_W = 6'(MAX_FALL);
    localparam logic [7:0]  ANIM_LAST  = 8'(ANIM_DIV - 1);
    localparam logic [5:0]  ID_STAND_W = 6'(ID_STAND);
    localparam logic [5:0]  ID_WALK0_W = 6'(ID_WALK0);
    localparam logic [5:0]  ID_JUMP_W  = 6'(ID_JUMP);
    localparam logic [5:0]  LEFT_OFS_W = 6'(LEFT_OFS);

    state_t      state, state_n;
    logic [5:0]  vy, vy_n;
    logic        facing_left, facing_n;
    logic [7:0]  anim_cnt, anim_n;
    logic [1:0]  frame, frame_n;
    logic        jump_prev, jump_prev_n;
    logic [10:0] x_n;
    logic [9:0]  y_n;
    logic [5:0]  id_n;
    logic [5:0]  base_id;
    logic        right_n, airborne_n;

    logic        mv_r, mv_l, jump_edge;
    logic [11:0] x_plus, x_minus;
    logic [10:0] y_sum;

    assign mv_r      = btn_right & ~btn_left;
    assign mv_l      = btn_left & ~btn_right;
    assign jump_edge = btn_jump & ~jump_prev;
    assign x_plus    = {1'b0, mario_x} + STEP_12;
    assign x_minus   = {1'b0, mario_x} - STEP_12;
    assign y_sum     = {1'b0, mario_y} + {5'b0, vy};

    always_comb begin
        state_n     = state;
        vy_n        = vy;
        facing_n    = facing_left;
        anim_n      = anim_cnt;
        frame_n     = frame;
        jump_prev_n = jump_prev;
        x_n         = mario_x;
        y_n         = mario_y;
        id_n        = mario_id;
        right_n     = right;
        airborne_n  = airborne;
        base_id     = ID_STAND_W;

        if (tick) begin
            jump_prev_n = btn_jump;
            right_n     = mv_r;

            // Left clamp compares before subtracting so x never wraps below X_MIN
            if (mv_r) begin
                facing_n = 1'b0;
                x_n      = (x_plus > X_MAX_12) ? X_MAX_W : x_plus[10:0];
            end else if (mv_l) begin
                facing_n = 1'b1;
                x_n      = ({1'b0, mario_x} >= X_MIN_12 + STEP_12) ? x_minus[10:0] : X_MIN_W;
            end

            case (state)
                IDLE, WALK: begin
                    if (jump_edge) begin
                        state_n = JUMP_UP;
                        vy_n    = JUMP_V_W;
                    end else begin
                        state_n = (mv_r | mv_l) ? WALK : IDLE;
                    end
                end
                JUMP_UP: begin
                    y_n  = (mario_y >= {4'b0, vy}) ? mario_y - {4'b0, vy} : 10'd0;
                    vy_n = vy - 6'd1;
                    if (vy == 6'd1) state_n = FALL;
                end
                FALL: begin
                    if (y_sum >= GROUND_11) begin
                        y_n     = GROUND_W;
                        vy_n    = 6'd0;
                        state_n = (mv_r | mv_l) ? WALK : IDLE;
                    end else begin
                        y_n  = y_sum[9:0];
                        vy_n = (vy >= MAX_FALL_W) ? MAX_FALL_W : vy + 6'd1;
                    end
                end
                default: state_n = IDLE;
            endcase

            // Entering WALK starts at frame 0; each frame lasts ANIM_DIV ticks
            if (state_n == WALK && state == WALK) begin
                if (anim_cnt == ANIM_LAST) begin
                    anim_n  = 8'd0;
                    frame_n = (frame == 2'd2) ? 2'd0 : frame + 2'd1;
                end else begin
                    anim_n = anim_cnt + 8'd1;
                end
            end else begin
                anim_n  = 8'd0;
                frame_n = 2'd0;
            end

            case (state_n)
                WALK:          base_id = ID_WALK0_W + {4'b0, frame_n};
                JUMP_UP, FALL: base_id = ID_JUMP_W;
                default:       base_id = ID_STAND_W;
            endcase
            id_n       = base_id + (facing_n ? LEFT_OFS_W : 6'd0);
            airborne_n = (state_n == JUMP_UP) || (state_n == FALL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            vy          <= 6'd0;
            facing_left <= 1'b0;
            anim_cnt    <= 8'd0;
            frame       <= 2'd0;
            jump_prev   <= 1'b0;
            mario_x     <= X_RESET_W;
            mario_y     <= GROUND_W;
            mario_id    <= ID_STAND_W;
            right       <= 1'b0;
            airborne    <= 1'b0;
        end else begin
            state       <= state_n;
            vy          <= vy_n;
            facing_left <= facing_n;
            anim_cnt    <= anim_n;
            frame       <= frame_n;
            jump_prev   <= jump_prev_n;
            mario_x     <= x_n;
            mario_y     <= y_n;
            mario_id    <= id_n;
            right       <= right_n;
            airborne    <= airborne_n;
        end
    end

endmodule

// File: tb/tb_mario_ctrl.sv
// Bench for mario_ctrl: a hand-computed vector table, then model-driven
// sequences whose expected outputs flow through a scoreboard queue.
module tb_mario_ctrl;

    localparam int X_RESET = 64, X_MIN = 0, X_MAX = 640, GROUND_Y = 704;
    localparam int WALK_STEP = 4, JUMP_V = 20, MAX_FALL = 16, ANIM_DIV = 4;
    localparam int ID_STAND = 10, ID_WALK0 = 11, ID_JUMP = 14, LEFT_OFS = 8;
    localparam int S_IDLE = 0, S_WALK = 1, S_UP = 2, S_FALL = 3;

    typedef struct {
        int x;
        int y;
        int id;
        int rt;
        int air;
    } exp_t;

    typedef struct {
        logic l;
        logic r;
        logic j;
        logic t;
        int   x;
        int   y;
        int   id;
        int   rt;
        int   air;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        tick = 1'b0;
    logic        btn_left = 1'b0;
    logic        btn_right = 1'b0;
    logic        btn_jump = 1'b0;
    logic [10:0] mario_x;
    logic [9:0]  mario_y;
    logic [5:0]  mario_id;
    logic        right;
    logic        airborne;

    int tests_run = 0;
    int tests_failed = 0;

    exp_t sb[$];
    vec_t vecs[15];

    int m_x, m_y, m_vy, m_st, m_face, m_cnt, m_frame, m_prev, m_right;

    mario_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .btn_left (btn_left),
        .btn_right(btn_right),
        .btn_jump (btn_jump),
        .mario_x  (mario_x),
        .mario_y  (mario_y),
        .mario_id (mario_id),
        .right    (right),
        .airborne (airborne)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_x = X_RESET; m_y = GROUND_Y; m_vy = 0; m_st = S_IDLE;
        m_face = 0; m_cnt = 0; m_frame = 0; m_prev = 0; m_right = 0;
    endtask

    task automatic model_step(input logic l, input logic r, input logic j, input logic t);
        int mr, ml, jedge, old_st;
        if (!t) return;
        mr = (r && !l) ? 1 : 0;
        ml = (l && !r) ? 1 : 0;
        jedge = (j && m_prev == 0) ? 1 : 0;
        m_prev = j ? 1 : 0;
        m_right = mr;
        old_st = m_st;
        if (mr == 1) begin
            m_x = m_x + WALK_STEP;
            if (m_x > X_MAX) m_x = X_MAX;
            m_face = 0;
        end else if (ml == 1) begin
            m_x = m_x - WALK_STEP;
            if (m_x < X_MIN) m_x = X_MIN;
            m_face = 1;
        end
        if (m_st == S_IDLE || m_st == S_WALK) begin
            if (jedge == 1) begin
                m_st = S_UP;
                m_vy = JUMP_V;
            end else begin
                m_st = (mr + ml > 0) ? S_WALK : S_IDLE;
            end
        end else if (m_st == S_UP) begin
            m_y = m_y - m_vy;
            if (m_y < 0) m_y = 0;
            m_vy = m_vy - 1;
            if (m_vy == 0) m_st = S_FALL;
        end else begin
            if (m_y + m_vy >= GROUND_Y) begin
                m_y = GROUND_Y;
                m_vy = 0;
                m_st = (mr + ml > 0) ? S_WALK : S_IDLE;
            end else begin
                m_y = m_y + m_vy;
                m_vy = (m_vy + 1 > MAX_FALL) ? MAX_FALL : m_vy + 1;
            end
        end
        if (m_st == S_WALK && old_st == S_WALK) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == ANIM_DIV) begin
                m_cnt = 0;
                m_frame = (m_frame + 1) % 3;
            end
        end else begin
            m_cnt = 0;
            m_frame = 0;
        end
    endtask

    function automatic exp_t model_exp();
        exp_t e;
        int base;
        if (m_st == S_UP || m_st == S_FALL) base = ID_JUMP;
        else if (m_st == S_WALK) base = ID_WALK0 + m_frame;
        else base = ID_STAND;
        e.x = m_x;
        e.y = m_y;
        e.id = base + (m_face == 1 ? LEFT_OFS : 0);
        e.rt = m_right;
        e.air = (m_st == S_UP || m_st == S_FALL) ? 1 : 0;
        return e;
    endfunction

    task automatic drive(input logic l, input logic r, input logic j, input logic t);
        @(negedge clk);
        btn_left = l;
        btn_right = r;
        btn_jump = j;
        tick = t;
    endtask

    task automatic apply_stimulus(input logic l, input logic r, input logic j, input logic t);
        drive(l, r, j, t);
        model_step(l, r, j, t);
        sb.push_back(model_exp());
    endtask

    task automatic compare(input string label, input exp_t e);
        tests_run++;
        if (int'(mario_x) != e.x || int'(mario_y) != e.y || int'(mario_id) != e.id ||
            int'(right) != e.rt || int'(airborne) != e.air) begin
            tests_failed++;
            $display("[TB] FAIL %s: got x=%0d y=%0d id=%0d right=%0d air=%0d, expected x=%0d y=%0d id=%0d right=%0d air=%0d",
                     label, mario_x, mario_y, mario_id, right, airborne,
                     e.x, e.y, e.id, e.rt, e.air);
        end
    endtask

    task automatic check_output(input string label);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL %s: scoreboard empty when output arrived", label);
        end else begin
            e = sb.pop_front();
            compare(label, e);
        end
    endtask

    task automatic check_value(input string label, input int got, input int want);
        tests_run++;
        if (got != want) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d, expected %0d", label, got, want);
        end
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
    endtask

    initial begin
        exp_t reset_exp;
        int min_y, jumps, prev_air;
        logic rl, rr, rj, rt;

        reset_exp = '{X_RESET, GROUND_Y, ID_STAND, 0, 0};

        //            l  r  j  t    x    y   id rt air
        vecs[0]  = '{0, 0, 0, 1,  64, 704, 10, 0, 0};
        vecs[1]  = '{0, 0, 0, 1,  64, 704, 10, 0, 0};
        vecs[2]  = '{0, 1, 0, 1,  68, 704, 11, 1, 0};
        vecs[3]  = '{0, 1, 0, 1,  72, 704, 11, 1, 0};
        vecs[4]  = '{0, 1, 0, 1,  76, 704, 11, 1, 0};
        vecs[5]  = '{0, 1, 0, 1,  80, 704, 11, 1, 0};
        vecs[6]  = '{0, 1, 0, 1,  84, 704, 12, 1, 0};
        vecs[7]  = '{1, 1, 0, 1,  84, 704, 10, 0, 0};
        vecs[8]  = '{0, 1, 0, 0,  84, 704, 10, 0, 0};
        vecs[9]  = '{1, 0, 0, 1,  80, 704, 19, 0, 0};
        vecs[10] = '{1, 0, 0, 1,  76, 704, 19, 0, 0};
        vecs[11] = '{0, 0, 0, 1,  76, 704, 18, 0, 0};
        vecs[12] = '{0, 0, 1, 1,  76, 704, 22, 0, 1};
        vecs[13] = '{0, 0, 0, 1,  76, 684, 22, 0, 1};
        vecs[14] = '{0, 1, 0, 1,  80, 665, 14, 1, 1};

        repeat (2) @(negedge clk);
        compare("reset_state", reset_exp);
        rst = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].l, vecs[i].r, vecs[i].j, vecs[i].t);
            sb.push_back('{vecs[i].x, vecs[i].y, vecs[i].id, vecs[i].rt, vecs[i].air});
            check_output($sformatf("vec%0d", i));
        end

        // Reset mid-jump must take effect without a clock edge
        drive(1'b0, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b0;
        #1 compare("async_reset_mid_jump", reset_exp);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_output("post_reset_idle");
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
            check_output("idle_ticks");
        end

        for (int i = 0; i < 200; i++) begin
            apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1);
            check_output("walk_right");
        end
        check_value("x_saturates_at_max", int'(mario_x), X_MAX);
        check_value("right_flag_at_max", int'(right), 1);

        do_reset();
        for (int i = 0; i < 20; i++) begin
            apply_stimulus(1'b1, 1'b0, 1'b0, 1'b1);
            check_output("walk_left");
        end
        check_value("x_clamps_at_min", int'(mario_x), X_MIN);

        do_reset();
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
        check_output("jump_start");
        min_y = GROUND_Y;
        for (int i = 0; i < 60; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
            check_output("jump_arc");
            if (int'(mario_y) < min_y) min_y = int'(mario_y);
        end
        check_value("jump_apex_y", min_y, 494);
        check_value("jump_lands_on_ground", int'(mario_y), GROUND_Y);

        do_reset();
        jumps = 0;
        prev_air = 0;
        for (int i = 0; i < 100; i++) begin
            apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
            check_output("jump_held");
            if (airborne && prev_air == 0) jumps++;
            prev_air = int'(airborne);
        end
        check_value("single_jump_when_held", jumps, 1);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_output("jump_released");
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b1);
        check_output("jump_repressed");
        check_value("rejump_after_release", int'(airborne), 1);

        do_reset();
        for (int i = 0; i < 300; i++) begin
            rl = 1'($urandom_range(0, 1));
            rr = 1'($urandom_range(0, 1));
            rj = ($urandom_range(0, 7) == 0);
            rt = ($urandom_range(0, 3) != 0);
            apply_stimulus(rl, rr, rj, rt);
            check_output("random");
        end

        drive(1'b0, 1'b0, 1'b0, 1'b0);
        if (sb.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL scoreboard_drain: got %0d leftover entries, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
